// File: rtl/refill_pkg.sv
// Shared definitions for the cache/DDR line refill engine: FSM encoding,
// burst length width and a constant-evaluable log2 helper.
package refill_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB_REQ  = 3'd1,
        WB_DATA = 3'd2,
        RF_REQ  = 3'd3,
        RF_DATA = 3'd4,
        DONE    = 3'd5
    } state_e;

    localparam int BURST_LEN_W = 10;

    function automatic int clog2(input int value);
        int r;
        for (r = 0; (1 << r) < value; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/cache_ddr_refill_engine_if.sv
// Burst request/data bus between the refill engine (master) and the DDR
// burst controller (slave).
interface cache_ddr_refill_engine_if #(
    parameter int DDR_DATA_WIDTH = 128,
    parameter int DDR_ADDR_WIDTH = 28
);
    import refill_pkg::*;

    logic                      rd_burst_req;
    logic [BURST_LEN_W-1:0]    rd_burst_len;
    logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr;
    logic                      rd_burst_data_valid;
    logic [DDR_DATA_WIDTH-1:0] rd_burst_data;
    logic                      rd_burst_finish;
    logic                      wr_burst_req;
    logic [BURST_LEN_W-1:0]    wr_burst_len;
    logic [DDR_ADDR_WIDTH-1:0] wr_burst_addr;
    logic                      wr_burst_data_req;
    logic [DDR_DATA_WIDTH-1:0] wr_burst_data;
    logic                      wr_burst_finish;

    modport master (
        output rd_burst_req, rd_burst_len, rd_burst_addr,
        input  rd_burst_data_valid, rd_burst_data, rd_burst_finish,
        output wr_burst_req, wr_burst_len, wr_burst_addr,
        input  wr_burst_data_req,
        output wr_burst_data,
        input  wr_burst_finish
    );

    modport slave (
        input  rd_burst_req, rd_burst_len, rd_burst_addr,
        output rd_burst_data_valid, rd_burst_data, rd_burst_finish,
        input  wr_burst_req, wr_burst_len, wr_burst_addr,
        output wr_burst_data_req,
        input  wr_burst_data,
        output wr_burst_finish
    );

endinterface

// File: rtl/refill_beat_counter.sv
// Beat counter for one line transfer: index, "next increment wraps" flag and
// a sticky full flag once LINE_BEATS increments have been taken.
module refill_beat_counter
    import refill_pkg::*;
#(
    parameter int LINE_BEATS = 8,
    parameter int IDX_W      = clog2(LINE_BEATS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W-1:0] count,
    output logic             wrap,
    output logic             full
);

    logic [IDX_W-1:0] count_q;
    logic             full_q;

    assign count = count_q;
    assign full  = full_q;
    assign wrap  = !full_q && (count_q == IDX_W'(LINE_BEATS - 1));

    // Increments are dropped once full so the index never re-walks the line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            full_q  <= 1'b0;
        end else if (clr) begin
            count_q <= '0;
            full_q  <= 1'b0;
        end else if (inc && !full_q) begin
            count_q <= count_q + IDX_W'(1);
            if (wrap) full_q <= 1'b1;
        end
    end

endmodule

// File: rtl/cache_ddr_refill_engine.sv
// Cache line refill engine: optional dirty-victim write-back burst followed
// by a line fetch burst. Optional perf counters under REFILL_PERF_CNT_EN.
module cache_ddr_refill_engine
    import refill_pkg::*;
#(
    parameter int DDR_DATA_WIDTH = 128,
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int LINE_BEATS     = 8,
    parameter int ADDR_STRIDE    = 8,
    localparam int IDX_W         = clog2(LINE_BEATS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ddr_ready,
    input  logic                      miss_req,
    input  logic [DDR_ADDR_WIDTH-1:0] miss_line_addr,
    input  logic                      miss_dirty,
    input  logic [DDR_ADDR_WIDTH-1:0] victim_line_addr,
    output logic                      miss_ack,
    output logic                      refill_done,
    output logic                      busy,
    output logic                      err,
    output logic                      cache_rd_en,
    output logic [IDX_W-1:0]          cache_rd_idx,
    input  logic [DDR_DATA_WIDTH-1:0] cache_rd_data,
    output logic                      cache_wr_en,
    output logic [IDX_W-1:0]          cache_wr_idx,
    output logic [DDR_DATA_WIDTH-1:0] cache_wr_data,
`ifdef REFILL_PERF_CNT_EN
    output logic [31:0]               perf_refills,
    output logic [31:0]               perf_writebacks,
    output logic [31:0]               perf_busy_cycles,
`endif
    cache_ddr_refill_engine_if.master ddr
);

    localparam logic [DDR_ADDR_WIDTH-1:0] LINE_MASK =
        ~DDR_ADDR_WIDTH'(LINE_BEATS * ADDR_STRIDE - 1);

    state_e                    state_q, state_d;
    logic [DDR_ADDR_WIDTH-1:0] line_addr_q, victim_addr_q;
    logic                      err_q, err_set;
    logic                      rd_pend_q;
    logic [DDR_DATA_WIDTH-1:0] wr_hold_q;
    logic                      rd_req, wr_req, cnt_clr, wb_inc, rf_inc;
    logic                      wb_wrap, wb_full, rf_wrap, rf_full;

    refill_beat_counter #(.LINE_BEATS(LINE_BEATS), .IDX_W(IDX_W)) u_wb_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(wb_inc),
        .count(cache_rd_idx), .wrap(wb_wrap), .full(wb_full)
    );

    refill_beat_counter #(.LINE_BEATS(LINE_BEATS), .IDX_W(IDX_W)) u_rf_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(rf_inc),
        .count(cache_wr_idx), .wrap(rf_wrap), .full(rf_full)
    );

    always_comb begin
        state_d     = state_q;
        miss_ack    = 1'b0;
        refill_done = 1'b0;
        cache_rd_en = 1'b0;
        cache_wr_en = 1'b0;
        rd_req      = 1'b0;
        wr_req      = 1'b0;
        wb_inc      = 1'b0;
        rf_inc      = 1'b0;
        cnt_clr     = 1'b0;
        err_set     = 1'b0;
        case (state_q)
            IDLE: begin
                if (miss_req && ddr_ready) begin
                    miss_ack = 1'b1;
                    state_d  = miss_dirty ? WB_REQ : RF_REQ;
                end
            end
            WB_REQ: begin
                if (ddr_ready) begin
                    wr_req  = 1'b1;
                    state_d = WB_DATA;
                end
            end
            WB_DATA: begin
                if (ddr.wr_burst_data_req) begin
                    if (wb_full) err_set = 1'b1;
                    else begin
                        cache_rd_en = 1'b1;
                        wb_inc      = 1'b1;
                    end
                end
                if (ddr.wr_burst_finish) begin
                    state_d = RF_REQ;
                    if (!(wb_full || (wb_inc && wb_wrap))) err_set = 1'b1;
                end
            end
            RF_REQ: begin
                if (ddr_ready) begin
                    rd_req  = 1'b1;
                    state_d = RF_DATA;
                end
            end
            RF_DATA: begin
                // A beat arriving with finish is written before the transition.
                if (ddr.rd_burst_data_valid) begin
                    if (rf_full) err_set = 1'b1;
                    else begin
                        cache_wr_en = 1'b1;
                        rf_inc      = 1'b1;
                    end
                end
                if (ddr.rd_burst_finish) begin
                    state_d = DONE;
                    if (!(rf_full || (rf_inc && rf_wrap))) err_set = 1'b1;
                end
            end
            DONE: begin
                refill_done = 1'b1;
                cnt_clr     = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_q != RF_DATA && (ddr.rd_burst_data_valid || ddr.rd_burst_finish))
            err_set = 1'b1;
        if (state_q != WB_DATA && (ddr.wr_burst_data_req || ddr.wr_burst_finish))
            err_set = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            line_addr_q   <= '0;
            victim_addr_q <= '0;
            err_q         <= 1'b0;
            rd_pend_q     <= 1'b0;
            wr_hold_q     <= '0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= cache_rd_en;
            if (rd_pend_q) wr_hold_q <= cache_rd_data;
            if (miss_ack) begin
                line_addr_q   <= miss_line_addr & LINE_MASK;
                victim_addr_q <= victim_line_addr & LINE_MASK;
                err_q         <= 1'b0;
            end
            if (err_set) err_q <= 1'b1;
        end
    end

    assign busy              = (state_q != IDLE);
    assign err               = err_q;
    assign cache_wr_data     = cache_wr_en ? ddr.rd_burst_data : '0;
    assign ddr.rd_burst_req  = rd_req;
    assign ddr.rd_burst_len  = BURST_LEN_W'(LINE_BEATS);
    assign ddr.rd_burst_addr = line_addr_q;
    assign ddr.wr_burst_req  = wr_req;
    assign ddr.wr_burst_len  = BURST_LEN_W'(LINE_BEATS);
    assign ddr.wr_burst_addr = victim_addr_q;
    // RAM word is forwarded in the cycle it returns, then held through stalls.
    assign ddr.wr_burst_data = rd_pend_q ? cache_rd_data : wr_hold_q;

`ifdef REFILL_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_refills     <= '0;
            perf_writebacks  <= '0;
            perf_busy_cycles <= '0;
        end else begin
            if (refill_done) perf_refills <= sat_inc(perf_refills);
            if (state_q == WB_DATA && ddr.wr_burst_finish)
                perf_writebacks <= sat_inc(perf_writebacks);
            if (busy) perf_busy_cycles <= sat_inc(perf_busy_cycles);
        end
    end
`endif

endmodule

// File: tb/tb_cache_ddr_refill_engine.sv
// Directed-plus-random bench for cache_ddr_refill_engine with a line-level
// reference model of write-back and refill transfers.
module tb_cache_ddr_refill_engine;
    import refill_pkg::*;

    localparam int DW = 128;
    localparam int AW = 28;
    localparam int LB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, ddr_ready, miss_req, miss_dirty;
    logic [AW-1:0] miss_line_addr, victim_line_addr;
    logic          miss_ack, refill_done, busy, err, cache_rd_en, cache_wr_en;
    logic [2:0]    cache_rd_idx, cache_wr_idx;
    logic [DW-1:0] cache_rd_data = '0;
    logic [DW-1:0] cache_wr_data;
`ifdef REFILL_PERF_CNT_EN
    logic [31:0]   perf_r, perf_w, perf_b;
`endif

    cache_ddr_refill_engine_if #(.DDR_DATA_WIDTH(DW), .DDR_ADDR_WIDTH(AW)) ddr_if ();

    cache_ddr_refill_engine dut (
        .clk(clk), .rst(rst), .ddr_ready(ddr_ready),
        .miss_req(miss_req), .miss_line_addr(miss_line_addr),
        .miss_dirty(miss_dirty), .victim_line_addr(victim_line_addr),
        .miss_ack(miss_ack), .refill_done(refill_done), .busy(busy), .err(err),
        .cache_rd_en(cache_rd_en), .cache_rd_idx(cache_rd_idx),
        .cache_rd_data(cache_rd_data), .cache_wr_en(cache_wr_en),
        .cache_wr_idx(cache_wr_idx), .cache_wr_data(cache_wr_data),
`ifdef REFILL_PERF_CNT_EN
        .perf_refills(perf_r), .perf_writebacks(perf_w), .perf_busy_cycles(perf_b),
`endif
        .ddr(ddr_if)
    );

    // Victim line contents held by the cache RAM; one-cycle read latency.
    logic [DW-1:0] victim_words [LB];
    always @(posedge clk) if (cache_rd_en) cache_rd_data <= victim_words[cache_rd_idx];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [AW-1:0] rnd_line();
        logic [AW-1:0] mask;
        mask = ~AW'(LB * 8 - 1);
        return AW'($urandom) & mask;
    endfunction

    // One miss transaction; expectations come from the line-transfer rules.
    task automatic run_miss(input logic [AW-1:0] line, input logic [AW-1:0] victim,
                            input bit dirty, input int rd_beats, input int gap);
        logic [DW-1:0] d;
        bit exp_err;
        exp_err = (rd_beats != LB);
        if (dirty) for (int k = 0; k < LB; k++) victim_words[k] = rnd_word();
        step();
        ddr_ready = 1'b1; miss_req = 1'b1; miss_dirty = dirty;
        miss_line_addr = line; victim_line_addr = victim;
        @(negedge clk);
        chk("miss_ack", miss_ack, 1); chk("idle_busy", busy, 0);
        step();
        miss_line_addr = line ^ AW'('h40);
        @(negedge clk);
        chk("ack_once", miss_ack, 0); chk("err_clr", err, 0); chk("busy", busy, 1);
        if (dirty) begin
            chk("wr_req", ddr_if.wr_burst_req, 1); chk("wr_addr", ddr_if.wr_burst_addr, victim);
            chk("wr_len", ddr_if.wr_burst_len, LB); chk("rd_req_excl", ddr_if.rd_burst_req, 0);
            for (int k = 0; k < LB; k++) begin
                step(); ddr_if.wr_burst_data_req = 1'b1;
                @(negedge clk);
                chk("wb_rd_en", cache_rd_en, 1); chk("wb_rd_idx", cache_rd_idx, k);
                chk("wb_no_req", ddr_if.wr_burst_req, 0);
                if (k > 0) chk("wb_data", ddr_if.wr_burst_data, victim_words[k-1]);
                for (int g = 0; g < gap; g++) begin
                    step(); ddr_if.wr_burst_data_req = 1'b0;
                    @(negedge clk);
                    chk("wb_hold", ddr_if.wr_burst_data, victim_words[k]);
                    chk("wb_no_extra_rd", cache_rd_en, 0);
                end
            end
            step(); ddr_if.wr_burst_data_req = 1'b0; ddr_if.wr_burst_finish = 1'b1;
            @(negedge clk);
            chk("wb_last", ddr_if.wr_burst_data, victim_words[LB-1]);
            chk("wb_rd_stop", cache_rd_en, 0);
            step(); ddr_if.wr_burst_finish = 1'b0;
            @(negedge clk);
        end
        chk("rd_req", ddr_if.rd_burst_req, 1); chk("rd_addr", ddr_if.rd_burst_addr, line);
        chk("rd_len", ddr_if.rd_burst_len, LB); chk("wr_req_excl", ddr_if.wr_burst_req, 0);
        for (int i = 0; i < rd_beats; i++) begin
            step();
            d = rnd_word();
            ddr_if.rd_burst_data_valid = 1'b1; ddr_if.rd_burst_data = d;
            ddr_if.rd_burst_finish = (i == rd_beats - 1);
            @(negedge clk);
            chk("rf_wr_en", cache_wr_en, (i < LB));
            if (i < LB) begin
                chk("rf_wr_idx", cache_wr_idx, i); chk("rf_wr_data", cache_wr_data, d);
            end
            chk("rf_no_done", refill_done, 0); chk("rf_no_ack", miss_ack, 0);
        end
        step();
        ddr_if.rd_burst_data_valid = 1'b0; ddr_if.rd_burst_finish = 1'b0; miss_req = 1'b0;
        @(negedge clk);
        chk("refill_done", refill_done, 1); chk("done_no_wr", cache_wr_en, 0);
        step();
        @(negedge clk);
        chk("done_once", refill_done, 0); chk("idle_after", busy, 0); chk("err", err, exp_err);
    endtask

    initial begin
        rst = 1'b0; ddr_ready = 1'b0; miss_req = 1'b0; miss_dirty = 1'b0;
        miss_line_addr = '0; victim_line_addr = '0;
        ddr_if.rd_burst_data_valid = 1'b0; ddr_if.rd_burst_data = '0;
        ddr_if.rd_burst_finish = 1'b0; ddr_if.wr_burst_data_req = 1'b0;
        ddr_if.wr_burst_finish = 1'b0;
        for (int k = 0; k < LB; k++) victim_words[k] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", miss_ack, 0); chk("rst_busy", busy, 0); chk("rst_err", err, 0);
        chk("rst_rd_req", ddr_if.rd_burst_req, 0); chk("rst_wr_req", ddr_if.wr_burst_req, 0);
        chk("rst_rd_en", cache_rd_en, 0); chk("rst_wr_en", cache_wr_en, 0);
        chk("rst_wr_data", ddr_if.wr_burst_data, 0);
        chk("rst_rd_len", ddr_if.rd_burst_len, LB); chk("rst_wr_len", ddr_if.wr_burst_len, LB);
        chk("rst_rd_addr", ddr_if.rd_burst_addr, 0); chk("rst_wr_addr", ddr_if.wr_burst_addr, 0);
        step(); rst = 1'b1;

        // Request while calibration incomplete must not be taken.
        miss_req = 1'b1; miss_line_addr = AW'('h400);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("not_ready_ack", miss_ack, 0); chk("not_ready_busy", busy, 0);
        end

        run_miss(AW'('h400), AW'('h0), 1'b0, LB, 0);
        run_miss(AW'('hC00), AW'('h800), 1'b1, LB, 0);
        run_miss(rnd_line(), rnd_line(), 1'b1, LB, 3);
        run_miss(rnd_line(), rnd_line(), 1'b0, 6, 0);
        run_miss(rnd_line(), rnd_line(), 1'b0, LB, 0);
        run_miss(rnd_line(), rnd_line(), 1'b1, LB + 1, 1);

        // Stray finish while idle flags an error without leaving IDLE.
        run_miss(rnd_line(), rnd_line(), 1'b0, LB, 0);
        step(); ddr_if.rd_burst_finish = 1'b1;
        step(); ddr_if.rd_burst_finish = 1'b0;
        @(negedge clk);
        chk("stray_err", err, 1); chk("stray_busy", busy, 0);

        // Asynchronous reset in the middle of the refill data phase.
        step(); ddr_ready = 1'b1; miss_req = 1'b1; miss_dirty = 1'b0; miss_line_addr = AW'('h400);
        step(); miss_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(); ddr_if.rd_burst_data_valid = 1'b1; ddr_if.rd_burst_data = rnd_word();
        end
        step(); ddr_if.rd_burst_data_valid = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", busy, 0); chk("arst_wr_en", cache_wr_en, 0);
        chk("arst_wr_data", cache_wr_data, 0); chk("arst_wr_idx", cache_wr_idx, 0);
        chk("arst_err", err, 0); chk("arst_rd_addr", ddr_if.rd_burst_addr, 0);
        step(); ddr_if.rd_burst_data_valid = 1'b0;
        step(); rst = 1'b1;
        run_miss(AW'('h400), AW'('h0), 1'b0, LB, 0);

        for (int t = 0; t < 4; t++)
            run_miss(rnd_line(), rnd_line(), bit'($urandom_range(0, 1)), LB,
                     int'($urandom_range(0, 2)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cache_ddr_refill_engine.md
Name: cache_ddr_refill_engine

Overview:
- Cache-side line-transfer engine sitting directly upstream of the DDR burst controller.
- On a cache miss it optionally writes back the dirty victim line from cache RAM as one DDR write burst, then fetches the missing line as one DDR read burst into cache RAM.
- Drives the controller's rd/wr burst request, length and address ports and moves the data beats.

Parameters:
- DDR_DATA_WIDTH, 128, beat width; equals cache RAM word width.
- DDR_ADDR_WIDTH, 28, DDR address width.
- LINE_BEATS, 8, beats per cache line; power of two, 2..512.
- ADDR_STRIDE, 8, DDR address increment per beat; line base must be aligned to LINE_BEATS*ADDR_STRIDE.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- ddr_ready  in  1  DDR calibration complete
- miss_req  in  1  miss request, level; sampled only in IDLE
- miss_line_addr  in  DDR_ADDR_WIDTH  DDR base address of line to fetch
- miss_dirty  in  1  victim line must be written back first
- victim_line_addr  in  DDR_ADDR_WIDTH  DDR base address of victim line
- miss_ack  out  1  one-cycle pulse when the request is captured
- refill_done  out  1  one-cycle pulse when the refill completes
- busy  out  1  high in every state except IDLE
- err  out  1  sticky protocol error; cleared by reset or the next miss_ack
- cache_rd_en  out  1  cache RAM read strobe; data returned 1 cycle later
- cache_rd_idx  out  log2(LINE_BEATS)  beat index of the read
- cache_rd_data  in  DDR_DATA_WIDTH  cache RAM read data
- cache_wr_en  out  1  cache RAM write strobe
- cache_wr_idx  out  log2(LINE_BEATS)  beat index of the write
- cache_wr_data  out  DDR_DATA_WIDTH  data written to cache RAM
- rd_burst_req  out  1  read burst request to DDR controller
- rd_burst_len  out  10  read burst length, constant LINE_BEATS
- rd_burst_addr  out  DDR_ADDR_WIDTH  read burst base address
- rd_burst_data_valid  in  1  read beat valid
- rd_burst_data  in  DDR_DATA_WIDTH  read beat data
- rd_burst_finish  in  1  read burst complete
- wr_burst_req  out  1  write burst request
- wr_burst_len  out  10  write burst length, constant LINE_BEATS
- wr_burst_addr  out  DDR_ADDR_WIDTH  write burst base address
- wr_burst_data_req  in  1  controller requests the next write beat
- wr_burst_data  out  DDR_DATA_WIDTH  write beat; valid the cycle after wr_burst_data_req
- wr_burst_finish  in  1  write burst complete

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all outputs 0 except rd_burst_len and wr_burst_len, which are constant LINE_BEATS; beat counters 0; captured addresses 0.
- Reset mid-burst aborts immediately and silently. The controller has its own reset; no recovery handshake.
- State IDLE:
  - if miss_req && ddr_ready: capture both addresses and miss_dirty, pulse miss_ack, clear err.
  - go to WB_REQ if miss_dirty, else RF_REQ.
- State WB_REQ:
  - if ddr_ready: assert wr_burst_req for exactly one cycle with wr_burst_addr = victim address, then go to WB_DATA.
  - if ddr_ready is low, stay in WB_REQ with wr_burst_req low.
- State WB_DATA:
  - each cycle with wr_burst_data_req: cache_rd_en=1, cache_rd_idx=wb_cnt; wb_cnt increments and wraps at LINE_BEATS.
  - wr_burst_data is a register loaded from cache_rd_data the cycle after cache_rd_en and held otherwise, so data stays stable while the controller stalls.
  - if wr_burst_data_req is seen while wb_cnt has already issued LINE_BEATS reads: set err and issue no read.
  - on wr_burst_finish: go to RF_REQ; set err if wb_cnt != LINE_BEATS.
- State RF_REQ:
  - if ddr_ready: one-cycle rd_burst_req with rd_burst_addr = miss address, then go to RF_DATA.
- State RF_DATA:
  - each rd_burst_data_valid: cache_wr_en=1, cache_wr_idx=rf_cnt, cache_wr_data=rd_burst_data, all combinational pass-through with zero latency; rf_cnt increments.
  - beats beyond LINE_BEATS are not written and set err.
  - on rd_burst_finish: go to DONE; set err if fewer than LINE_BEATS beats arrived.
  - a valid beat and finish arriving in the same cycle: write the beat, then take the transition.
- State DONE: pulse refill_done for one cycle, clear counters, go to IDLE.
- Stray inputs: rd_burst_data_valid or rd_burst_finish outside RF_DATA, and wr_burst_data_req or wr_burst_finish outside WB_DATA, are ignored and set err.
- Requests: never more than one outstanding request; rd_burst_req and wr_burst_req are never high together.
- Latency, clean miss: miss_ack at cycle 0; rd_burst_req at cycle 1 (ddr_ready high); refill_done 1 cycle after rd_burst_finish.

Optional Feature:
- Macro REFILL_PERF_CNT_EN.
- Defined: adds outputs perf_refills, perf_writebacks, perf_busy_cycles, each 32 bits.
  - perf_refills increments on refill_done.
  - perf_writebacks increments on wr_burst_finish in WB_DATA.
  - perf_busy_cycles increments every cycle busy is high.
  - All saturate at all-ones and reset to 0.
- Undefined: these ports and their logic do not exist. Functional behaviour is otherwise identical.

Decomposition:
- Shared package refill_pkg holds:
  - state encoding: IDLE, WB_REQ, WB_DATA, RF_REQ, RF_DATA, DONE (3 bits);
  - constant BURST_LEN_W = 10;
  - function clog2 for index width.
- One natural sub-module: refill_beat_counter, instantiated twice (wb_cnt, rf_cnt). It provides count, wrap and overflow flag, with synchronous clear and increment.

Test Plan:
- Clean miss, miss_line_addr=0x0000400 → one rd_burst_req with addr 0x0000400, len 8; 8 beats D0..D7 written to idx 0..7; refill_done 1 cycle after rd_burst_finish; err=0.
- Dirty miss, victim 0x0000800, line 0x0000C00 → wr_burst_req first with addr 0x0000800; cache_rd_idx 0..7 in order; wr_burst_data equals RAM word k one cycle after the k-th wr_burst_data_req; then rd_burst_req with addr 0x0000C00; refill_done once.
- Write-side stall: wr_burst_data_req gaps of 3 cycles between beats → wr_burst_data held stable through each gap; no extra cache reads.
- Short read: only 6 valid beats before rd_burst_finish → err=1, refill_done still pulses; next miss_ack clears err.
- miss_req asserted while ddr_ready=0 → no miss_ack. Raise ddr_ready → miss_ack next cycle. Second miss_req while busy is ignored until IDLE.
- Reset asserted mid-RF_DATA, after beat 3 → all outputs 0 asynchronously; after release, a new miss runs from beat index 0.
